// File: rtl/ir_barcode_pwm_ctrl.sv
// PWM/sequencer front end for the IR/barcode LED driver macro.
// IR: symbol FIFO played out as a carrier envelope after a warm-up; barcode: prescaled PWM.
module ir_barcode_pwm_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WARMUP_CYC = 64,
    parameter int unsigned BAR_PRESC  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ir_car_period,
    input  logic [7:0]  ir_car_high,
    input  logic        sym_valid,
    output logic        sym_ready,
    input  logic [15:0] sym_data,
    output logic        ir_busy,
    input  logic        bar_req,
    input  logic [7:0]  bar_period,
    input  logic [7:0]  bar_duty,
    output logic        ir_pwm,
    output logic        irled_en,
    output logic        barcode_pwm,
    output logic        barcode_en
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned WW = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
    localparam int unsigned PW = (BAR_PRESC > 1) ? $clog2(BAR_PRESC) : 1;

    typedef enum logic [1:0] {IR_IDLE, IR_WARMUP, IR_PLAY} ir_state_e;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt, cnt_n;
    logic          wr_en, pop;
    logic [15:0]   head;

    ir_state_e     st, st_n;
    logic [WW-1:0] wc, wc_n;
    logic [7:0]    cc, cc_n, per_l, per_n, high_l, high_n;
    logic [14:0]   dur, dur_n;
    logic          mark, mark_n;

    logic          b_act, b_act_n;
    logic [PW-1:0] pc, pc_n;
    logic [7:0]    tc, tc_n, bper, bper_n, bduty, bduty_n;

    assign wr_en = sym_valid && sym_ready;
    assign head  = mem[rd_ptr];
    assign cnt_n = cnt + CW'(wr_en) - CW'(pop);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= sym_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            sym_ready <= 1'b1;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            cnt       <= cnt_n;
            sym_ready <= (cnt_n != CW'(FIFO_DEPTH));
        end
    end

    always_comb begin
        st_n   = st;
        wc_n   = wc;
        cc_n   = cc;
        dur_n  = dur;
        mark_n = mark;
        per_n  = per_l;
        high_n = high_l;
        pop    = 1'b0;
        case (st)
            IR_IDLE: begin
                if (cnt != '0) begin
                    st_n   = IR_WARMUP;
                    wc_n   = '0;
                    per_n  = ir_car_period;
                    high_n = ir_car_high;
                end
            end
            IR_WARMUP: begin
                if (wc == WW'(WARMUP_CYC - 1)) begin
                    pop    = 1'b1;
                    st_n   = IR_PLAY;
                    cc_n   = '0;
                    mark_n = head[15];
                    dur_n  = (head[14:0] == '0) ? 15'd1 : head[14:0];
                end else begin
                    wc_n = wc + WW'(1);
                end
            end
            IR_PLAY: begin
                if (cc == per_l) begin
                    cc_n = '0;
                    if (dur == 15'd1) begin
                        if (cnt != '0) begin
                            pop    = 1'b1;
                            mark_n = head[15];
                            dur_n  = (head[14:0] == '0) ? 15'd1 : head[14:0];
                        end else begin
                            st_n   = IR_IDLE;
                            mark_n = 1'b0;
                            dur_n  = '0;
                        end
                    end else begin
                        dur_n = dur - 15'd1;
                    end
                end else begin
                    cc_n = cc + 8'd1;
                end
            end
            default: st_n = IR_IDLE;
        endcase
    end

    // Enable/busy stay up one cycle past PLAY so they cover the registered ir_pwm of the last cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= IR_IDLE;
            wc       <= '0;
            cc       <= '0;
            dur      <= '0;
            mark     <= 1'b0;
            per_l    <= '0;
            high_l   <= '0;
            ir_pwm   <= 1'b0;
            irled_en <= 1'b0;
            ir_busy  <= 1'b0;
        end else begin
            st       <= st_n;
            wc       <= wc_n;
            cc       <= cc_n;
            dur      <= dur_n;
            mark     <= mark_n;
            per_l    <= per_n;
            high_l   <= high_n;
            ir_pwm   <= (st == IR_PLAY) && mark && (cc < high_l);
            irled_en <= (st_n != IR_IDLE) || (st == IR_PLAY);
            ir_busy  <= (st_n != IR_IDLE) || (st == IR_PLAY);
        end
    end

    always_comb begin
        b_act_n = b_act;
        pc_n    = pc;
        tc_n    = tc;
        bper_n  = bper;
        bduty_n = bduty;
        if (!b_act) begin
            pc_n = '0;
            tc_n = '0;
            if (bar_req) begin
                b_act_n = 1'b1;
                bper_n  = bar_period;
                bduty_n = bar_duty;
            end
        end else if (pc == PW'(BAR_PRESC - 1)) begin
            pc_n = '0;
            if (tc == bper) begin
                tc_n = '0;
                if (bar_req) begin
                    bper_n  = bar_period;
                    bduty_n = bar_duty;
                end else begin
                    b_act_n = 1'b0;
                end
            end else begin
                tc_n = tc + 8'd1;
            end
        end else begin
            pc_n = pc + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_act       <= 1'b0;
            pc          <= '0;
            tc          <= '0;
            bper        <= '0;
            bduty       <= '0;
            barcode_en  <= 1'b0;
            barcode_pwm <= 1'b0;
        end else begin
            b_act       <= b_act_n;
            pc          <= pc_n;
            tc          <= tc_n;
            bper        <= bper_n;
            bduty       <= bduty_n;
            barcode_en  <= b_act_n;
            barcode_pwm <= b_act_n && (tc_n < bduty_n);
        end
    end
endmodule

// File: tb/tb_ir_barcode_pwm_ctrl.sv
// Directed self-checking bench for ir_barcode_pwm_ctrl (WARMUP_CYC=4, BAR_PRESC=2, FIFO_DEPTH=4).
module tb_ir_barcode_pwm_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  ir_car_period, ir_car_high, bar_period, bar_duty;
    logic        sym_valid, sym_ready, ir_busy, bar_req;
    logic [15:0] sym_data;
    logic        ir_pwm, irled_en, barcode_pwm, barcode_en;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [15:0] bp_data [6];
    logic [15:0] ch_data [3];

    always #5 clk = ~clk;

    ir_barcode_pwm_ctrl #(
        .FIFO_DEPTH(4),
        .WARMUP_CYC(4),
        .BAR_PRESC (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ir_car_period(ir_car_period),
        .ir_car_high  (ir_car_high),
        .sym_valid    (sym_valid),
        .sym_ready    (sym_ready),
        .sym_data     (sym_data),
        .ir_busy      (ir_busy),
        .bar_req      (bar_req),
        .bar_period   (bar_period),
        .bar_duty     (bar_duty),
        .ir_pwm       (ir_pwm),
        .irled_en     (irled_en),
        .barcode_pwm  (barcode_pwm),
        .barcode_en   (barcode_en)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bp_data = '{16'h8001, 16'h0001, 16'h8002, 16'h8001, 16'h0005, 16'h0005};
        ch_data = '{16'h8000, 16'h8001, 16'h8003};
        rst_n = 1'b0;
        ir_car_period = '0; ir_car_high = '0;
        sym_valid = 1'b0; sym_data = '0;
        bar_req = 1'b0; bar_period = '0; bar_duty = '0;

        // Reset state
        #12;
        chk("rst_ir_pwm", ir_pwm, 0);
        chk("rst_irled_en", irled_en, 0);
        chk("rst_ir_busy", ir_busy, 0);
        chk("rst_bar_pwm", barcode_pwm, 0);
        chk("rst_bar_en", barcode_en, 0);
        chk("rst_sym_ready", sym_ready, 1);
        rst_n = 1'b1;
        step();
        step();

        // Basic frame: period 9, high 3, mark/2 then space/1
        ir_car_period = 8'd9; ir_car_high = 8'd3;
        sym_valid = 1'b1; sym_data = 16'h8002;
        step();
        sym_data = 16'h0001;
        step();
        sym_valid = 1'b0;
        for (int j = 0; j < 40; j++) begin
            chk($sformatf("basic_pwm[%0d]", j), ir_pwm, ((j >= 5 && j <= 7) || (j >= 15 && j <= 17)) ? 1 : 0);
            chk($sformatf("basic_en[%0d]", j), irled_en, (j <= 34) ? 1 : 0);
            chk($sformatf("basic_busy[%0d]", j), ir_busy, (j <= 34) ? 1 : 0);
            step();
        end

        // Backpressure: 6 writes held, only 4 accepted
        ir_car_period = 8'd0; ir_car_high = 8'd1;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("bp_ready[%0d]", i), sym_ready, (i < 4) ? 1 : 0);
            chk($sformatf("bp_en[%0d]", i), irled_en, (i >= 2) ? 1 : 0);
            sym_valid = 1'b1; sym_data = bp_data[i];
            step();
        end
        sym_valid = 1'b0;
        for (int t = 6; t <= 16; t++) begin
            chk($sformatf("bp_ready[%0d]", t), sym_ready, 1);
            chk($sformatf("bp_pwm[%0d]", t), ir_pwm, (t == 7 || t == 9 || t == 10 || t == 11) ? 1 : 0);
            chk($sformatf("bp_en[%0d]", t), irled_en, (t <= 11) ? 1 : 0);
            step();
        end

        // Chaining with high = 0 (never pulses) and high = 255 (steady high)
        ir_car_period = 8'd3; ir_car_high = 8'd0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ch0_en[%0d]", i), irled_en, (i == 2) ? 1 : 0);
            sym_valid = 1'b1; sym_data = ch_data[i];
            step();
        end
        sym_valid = 1'b0;
        for (int t = 3; t <= 30; t++) begin
            chk($sformatf("ch0_pwm[%0d]", t), ir_pwm, 0);
            chk($sformatf("ch0_en[%0d]", t), irled_en, (t <= 26) ? 1 : 0);
            step();
        end
        ir_car_high = 8'd255;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ch1_en[%0d]", i), irled_en, (i == 2) ? 1 : 0);
            sym_valid = 1'b1; sym_data = ch_data[i];
            step();
        end
        sym_valid = 1'b0;
        for (int t = 3; t <= 30; t++) begin
            chk($sformatf("ch1_pwm[%0d]", t), ir_pwm, (t >= 7 && t <= 26) ? 1 : 0);
            chk($sformatf("ch1_en[%0d]", t), irled_en, (t <= 26) ? 1 : 0);
            step();
        end

        // Barcode: period 3, duty 1 -> duty 3 mid-period -> stop
        bar_period = 8'd3; bar_duty = 8'd1;
        chk("bar_idle_en", barcode_en, 0);
        bar_req = 1'b1;
        step();
        for (int b = 1; b <= 36; b++) begin
            if (b == 12) bar_duty = 8'd3;
            if (b == 28) bar_req = 1'b0;
            if (b <= 32) begin
                chk($sformatf("bar_pwm[%0d]", b), barcode_pwm,
                    (((b - 1) % 8) < ((b < 17) ? 2 : 6)) ? 1 : 0);
                chk($sformatf("bar_en[%0d]", b), barcode_en, 1);
            end else begin
                chk($sformatf("bar_pwm[%0d]", b), barcode_pwm, 0);
                chk($sformatf("bar_en[%0d]", b), barcode_en, 0);
            end
            step();
        end

        // Barcode extremes: duty 0 then duty 200
        bar_duty = 8'd0; bar_req = 1'b1;
        chk("barx_idle_en", barcode_en, 0);
        step();
        for (int b = 1; b <= 43; b++) begin
            if (b == 20) bar_duty = 8'd200;
            if (b == 40) bar_req = 1'b0;
            chk($sformatf("barx_pwm[%0d]", b), barcode_pwm, (b >= 25 && b <= 40) ? 1 : 0);
            chk($sformatf("barx_en[%0d]", b), barcode_en, (b <= 40) ? 1 : 0);
            step();
        end

        // Asynchronous reset during PLAY and an active barcode period
        ir_car_period = 8'd9; ir_car_high = 8'd255;
        bar_period = 8'd3; bar_duty = 8'd200; bar_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sym_valid = 1'b1; sym_data = 16'h8005;
            step();
        end
        sym_valid = 1'b0;
        for (int i = 3; i < 10; i++) step();
        chk("pre_rst_ir_pwm", ir_pwm, 1);
        chk("pre_rst_irled_en", irled_en, 1);
        chk("pre_rst_bar_pwm", barcode_pwm, 1);
        chk("pre_rst_bar_en", barcode_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ir_pwm", ir_pwm, 0);
        chk("arst_irled_en", irled_en, 0);
        chk("arst_ir_busy", ir_busy, 0);
        chk("arst_bar_pwm", barcode_pwm, 0);
        chk("arst_bar_en", barcode_en, 0);
        chk("arst_sym_ready", sym_ready, 1);
        bar_req = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("post_rst_busy[%0d]", k), ir_busy, 0);
            chk($sformatf("post_rst_en[%0d]", k), irled_en, 0);
            chk($sformatf("post_rst_pwm[%0d]", k), ir_pwm, 0);
            chk($sformatf("post_rst_bar_en[%0d]", k), barcode_en, 0);
            chk($sformatf("post_rst_ready[%0d]", k), sym_ready, 1);
        end
        ir_car_period = 8'd0; ir_car_high = 8'd1;
        sym_valid = 1'b1; sym_data = 16'h8001;
        step();
        sym_valid = 1'b0;
        chk("restart_en_c1", irled_en, 0);
        step();
        chk("restart_en_c2", irled_en, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ir_barcode_pwm_ctrl.md
Name: ir_barcode_pwm_ctrl

Overview:
- Digital PWM/sequencer stage directly upstream of the IR/barcode LED driver macro.
- Generates ir_pwm, irled_en, barcode_pwm and barcode_en for that macro.
- IR channel: buffers mark/space symbols in a small FIFO and plays them out as a carrier-modulated envelope. An enable warm-up period is inserted before the first pulse so the analog driver can settle.
- Barcode channel: a free-running prescaled PWM with glitch-free period/duty updates.

Parameters:
- FIFO_DEPTH, 4, IR symbol FIFO entries; power of two, 2..16.
- WARMUP_CYC, 64, clk cycles irled_en is high before the first carrier edge of a frame; must be ≥1.
- BAR_PRESC, 16, clk cycles per barcode PWM tick; must be ≥1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ir_car_period  input  8  carrier period minus 1, in clk cycles.
- ir_car_high  input  8  carrier high time, in clk cycles.
- sym_valid  input  1  symbol write valid.
- sym_ready  output  1  FIFO not full.
- sym_data  input  16  [15] = 1 mark / 0 space; [14:0] = duration in carrier periods.
- ir_busy  output  1  IR frame in progress (warm-up or playing).
- bar_req  input  1  barcode channel request.
- bar_period  input  8  barcode period minus 1, in ticks.
- bar_duty  input  8  barcode high ticks.
- ir_pwm  output  1  to driver ir_pwm.
- irled_en  output  1  to driver irled_en.
- barcode_pwm  output  1  to driver barcode_pwm.
- barcode_en  output  1  to driver barcode_en.

Behaviour:
- Reset: all outputs 0 except sym_ready = 1. FIFO empty, FSM in IDLE, all counters 0.
- Reset is asynchronous and may be asserted at any point. It forces all outputs low immediately and discards FIFO contents.
- All outputs are registered.
- FIFO write: occurs when sym_valid && sym_ready.
  - A write in the same cycle as a pop while full is not accepted, because sym_ready is computed from the registered count.
  - Count never exceeds FIFO_DEPTH.
- IR FSM states: IDLE, WARMUP, PLAY.
- IDLE:
  - irled_en = 0, ir_pwm = 0, ir_busy = 0.
  - When the FIFO is non-empty, go to WARMUP next cycle. In that cycle, irled_en = 1 and ir_busy = 1, and ir_car_period / ir_car_high are latched for the whole frame.
- WARMUP:
  - Lasts exactly WARMUP_CYC cycles with irled_en = 1 and ir_pwm = 0.
  - On the last cycle, pop the head symbol and go to PLAY.
- PLAY:
  - The carrier counter cc runs 0..ir_car_period and restarts at 0 on every symbol load.
  - carrier = (cc < ir_car_high), so ir_car_high = 0 gives no pulses and ir_car_high > ir_car_period gives a steady high.
  - ir_pwm = carrier & mark.
  - The duration counter decrements on each cc wrap. A duration of 0 is treated as 1.
- Symbol end (last cycle of the last carrier period):
  - If the FIFO is non-empty, pop the next symbol in the same cycle; it starts next cycle with no gap.
  - Otherwise go to IDLE, and irled_en and ir_busy fall next cycle.
- First pulse timing: the first ir_pwm high, for a mark, occurs WARMUP_CYC+1 cycles after irled_en rises.
- Late writes: symbols written during PLAY extend the frame only if present at a symbol-end boundary.
- Barcode channel:
  - The prescaler divides clk by BAR_PRESC into a tick. The tick counter tc runs 0..bar_period.
  - Idle: when bar_req = 0 and the current period has finished, barcode_en = 0 and barcode_pwm = 0; counters are held at 0.
  - Start: bar_req rising starts a period on the next cycle with barcode_en = 1. bar_period and bar_duty are sampled at each period start only.
  - barcode_pwm = (tc < duty_latched). Duty 0 gives always low; duty > period gives always high.
  - Stop: bar_req falling completes the current period, then deasserts barcode_en. There are no truncated pulses.
- The IR and barcode channels are fully independent.

Test Plan:
- Basic frame: WARMUP_CYC = 4, period = 9, high = 3; push mark/2 then space/1. Required: irled_en rises; 5 cycles later ir_pwm gives 2 pulses of 3 clk high on a 10-clk pitch, then 10 cycles low. irled_en falls 1 cycle after the 30-cycle play ends.
- FIFO full/backpressure: with FIFO_DEPTH = 4, hold sym_valid for 6 writes while IDLE. Required: exactly 4 accepted (the 4th while FIFO empty-then-popping counts at registered level); sym_ready = 0 while count = 4; it returns to 1 one cycle after the first pop.
- Seamless chaining and edge cases: push three marks of duration 0/1/3 with ir_car_high = 0, then ir_car_high = 255. Required: first case gives ir_pwm constantly 0 for 1+1+3 periods; second case gives ir_pwm high continuously across symbol boundaries with no gap.
- Barcode: BAR_PRESC = 2, period = 3, duty = 1. Then change duty to 3 mid-period, then drop bar_req. Required: 2 high / 6 low clocks repeating; the new duty applies only from the next period start (6 high / 2 low); barcode_en falls only after the period completes.
- Barcode extremes: duty = 0 gives barcode_pwm stuck at 0 with barcode_en = 1; duty = 200 with period = 3 gives barcode_pwm stuck at 1.
- Reset mid-operation: assert rst_n low during PLAY and during a barcode period. Required: all outputs go to 0 asynchronously and the FIFO is empty. After release, the block stays IDLE until new symbols are written.
